// File: rtl/mem_ctrl.sv
// Shares the single byte-wide memory port between instruction fetch and load/store.
// Word accesses are serialised into byte cycles, little-endian, with freeze/recovery on rdy_in=0.
module mem_ctrl #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_HOLD = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clr_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic              gnt_ls_q, gnt_ls_d;
    logic              last_ls_q, last_ls_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        iss_q, iss_d;
    logic [2:0]        cap_q, cap_d;
    logic              iss_vld_q, iss_vld_d;
    logic              cap_vld_q, cap_vld_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;

    logic              if_go, ls_go;
    logic [31:0]       nbuf;
    logic [2:0]        ls_n;

    always_comb begin
        state_d    = state_q;
        gnt_ls_d   = gnt_ls_q;
        last_ls_d  = last_ls_q;
        base_d     = base_q;
        n_d        = n_q;
        iss_d      = iss_q;
        cap_d      = cap_q;
        iss_vld_d  = iss_vld_q;
        cap_vld_d  = cap_vld_q;
        buf_d      = buf_q;
        wdata_d    = wdata_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = if_done_q;
        ls_done_d  = ls_done_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;

        // A flushed fetch is never granted; on a tie the requester not served last wins.
        if_go = if_req && !clr_in;
        ls_go = ls_req && (!if_go || !last_ls_q);
        ls_n  = (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
        nbuf  = buf_q;
        nbuf[{cap_q[1:0], 3'b000} +: 8] = mem_din;

        if (rdy_in) begin
            unique case (state_q)
                IDLE: begin
                    if (ls_go || if_go) begin
                        gnt_ls_d  = ls_go;
                        last_ls_d = ls_go;
                        base_d    = ls_go ? ls_addr : if_addr;
                        mem_a_d   = ls_go ? ls_addr : if_addr;
                        n_d       = ls_go ? ls_n : 3'd4;
                        wdata_d   = ls_wdata;
                        iss_d     = 3'd1;
                        cap_d     = 3'd0;
                        iss_vld_d = 1'b1;
                        cap_vld_d = 1'b0;
                        buf_d     = '0;
                        if (ls_go && ls_wr) begin
                            state_d    = WRITE;
                            mem_wr_d   = 1'b1;
                            mem_dout_d = ls_wdata[7:0];
                        end else begin
                            state_d = READ;
                        end
                    end
                end
                READ: begin
                    if (!gnt_ls_q && clr_in) begin
                        state_d   = IDLE;
                        mem_a_d   = IO_HOLD;
                        iss_vld_d = 1'b0;
                        cap_vld_d = 1'b0;
                    end else begin
                        // mem_din is valid only if an address was issued last cycle
                        cap_vld_d = iss_vld_q;
                        if (cap_vld_q) begin
                            buf_d = nbuf;
                            cap_d = cap_q + 3'd1;
                        end
                        if (cap_vld_q && (cap_q + 3'd1 == n_q)) begin
                            state_d   = DONE;
                            mem_a_d   = IO_HOLD;
                            iss_vld_d = 1'b0;
                            cap_vld_d = 1'b0;
                            if (gnt_ls_q) begin
                                ls_done_d  = 1'b1;
                                ls_rdata_d = nbuf;
                            end else begin
                                if_done_d = 1'b1;
                                if_data_d = nbuf;
                            end
                        end else if (iss_q < n_q) begin
                            mem_a_d   = base_q + ADDR_W'(iss_q);
                            iss_d     = iss_q + 3'd1;
                            iss_vld_d = 1'b1;
                        end else begin
                            mem_a_d   = IO_HOLD;
                            iss_vld_d = 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (iss_q < n_q) begin
                        mem_a_d    = base_q + ADDR_W'(iss_q);
                        mem_dout_d = wdata_q[{iss_q[1:0], 3'b000} +: 8];
                        iss_d      = iss_q + 3'd1;
                    end else begin
                        state_d   = DONE;
                        mem_wr_d  = 1'b0;
                        mem_a_d   = IO_HOLD;
                        ls_done_d = 1'b1;
                    end
                end
                DONE: begin
                    state_d   = IDLE;
                    if_done_d = 1'b0;
                    ls_done_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == READ) begin
            // Bytes issued during the pause are lost; restart from the first uncaptured one.
            mem_a_d   = base_q + ADDR_W'(cap_q);
            iss_d     = cap_q + 3'd1;
            iss_vld_d = 1'b1;
            cap_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            gnt_ls_q   <= 1'b0;
            last_ls_q  <= 1'b0;
            base_q     <= '0;
            n_q        <= 3'd0;
            iss_q      <= 3'd0;
            cap_q      <= 3'd0;
            iss_vld_q  <= 1'b0;
            cap_vld_q  <= 1'b0;
            buf_q      <= '0;
            wdata_q    <= '0;
            mem_a_q    <= IO_HOLD;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_ls_q   <= gnt_ls_d;
            last_ls_q  <= last_ls_d;
            base_q     <= base_d;
            n_q        <= n_d;
            iss_q      <= iss_d;
            cap_q      <= cap_d;
            iss_vld_q  <= iss_vld_d;
            cap_vld_q  <= cap_vld_d;
            buf_q      <= buf_d;
            wdata_q    <= wdata_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q && rdy_in;
    assign if_done  = if_done_q;
    assign ls_done  = ls_done_q;
    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model with one-cycle read latency, scoreboard of expected completions.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clr_in;
    logic        if_req, ls_req, ls_wr;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [1:0]  ls_size;
    logic        if_done, ls_done, mem_wr;
    logic [31:0] if_data, ls_rdata, mem_a;
    logic [7:0]  mem_din, mem_dout;

    typedef struct {
        logic        is_ls;
        logic        cmp;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         wr_cnt = 0;
    logic [7:0] ram [0:65535];

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk_in = ~clk_in;

    // While paused the bus belongs to the debugger, so the byte returned next cycle is junk.
    always @(posedge clk_in) begin
        mem_din <= rdy_in ? ram[mem_a[15:0]] : 8'hEE;
        if (mem_wr) begin
            ram[mem_a[15:0]] <= mem_dout;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = ram[16'(a + 32'(i))];
        return r;
    endfunction

    always @(negedge clk_in) begin : mon
        exp_t e;
        if (!rst_in && (if_done || ls_done)) begin
            chk("both_done", 32'(if_done && ls_done), 32'd0);
            if (exp_q.size() == 0) begin
                chk("done_without_req", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("done_src", 32'(ls_done), 32'(e.is_ls));
                if (e.cmp) chk(e.is_ls ? "ls_rdata" : "if_data", e.is_ls ? ls_rdata : if_data, e.data);
            end
        end
    end

    task automatic wait_done(input bit ls, input string tag);
        int t = 0;
        do begin
            @(negedge clk_in);
            t++;
        end while (!(ls ? ls_done : if_done) && t < 100);
        if (t >= 100) chk(tag, 32'(ls ? ls_done : if_done), 32'd1);
    endtask

    task automatic ls_op(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        @(posedge clk_in); #1;
        ls_req = 1'b1; ls_wr = wr; ls_size = sz; ls_addr = a; ls_wdata = wd;
        exp_q.push_back('{is_ls: 1'b1, cmp: !wr, data: wr ? 32'd0 : rd(a, n)});
        wait_done(1'b1, "ls_timeout");
        ls_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int wc0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'(i * 7 + 3);
        ram[16'h100] = 8'h11; ram[16'h101] = 8'h22; ram[16'h102] = 8'h33; ram[16'h103] = 8'h44;
        ram[16'h104] = 8'h55; ram[16'h105] = 8'h66; ram[16'h106] = 8'h77; ram[16'h107] = 8'h88;
        rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = '0; ls_wdata = '0;

        // reset state
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_ls_done", 32'(ls_done), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        rst_in = 1'b0;

        // ties right after reset: LS first, then alternating
        @(posedge clk_in); #1;
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd3; ls_addr = 32'h2000;
        exp_q.push_back('{is_ls: 1'b1, cmp: 1'b1, data: rd(32'h2000, 4)});
        exp_q.push_back('{is_ls: 1'b0, cmp: 1'b1, data: 32'h44332211});
        exp_q.push_back('{is_ls: 1'b1, cmp: 1'b1, data: rd(32'h2001, 2)});
        exp_q.push_back('{is_ls: 1'b0, cmp: 1'b1, data: 32'h88776655});
        fork
            begin
                wait_done(1'b1, "t3_ls_timeout");
                ls_addr = 32'h2001; ls_size = 2'd1;
                wait_done(1'b1, "t3_ls_timeout");
                ls_req = 1'b0;
            end
            begin
                wait_done(1'b0, "t3_if_timeout");
                if_addr = 32'h104;
                wait_done(1'b0, "t3_if_timeout");
                if_req = 1'b0;
            end
        join

        // plain fetch with cycle-exact address sequence
        exp_q.push_back('{is_ls: 1'b0, cmp: 1'b1, data: 32'h44332211});
        @(posedge clk_in); #1;
        if_req = 1'b1; if_addr = 32'h100;
        @(posedge clk_in);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            chk("t1_mem_a", mem_a, 32'h100 + 32'(k));
            chk("t1_mem_wr", 32'(mem_wr), 32'd0);
        end
        @(negedge clk_in); chk("t1_done_early", 32'(if_done), 32'd0);
        @(negedge clk_in); chk("t1_done_cyc6", 32'(if_done), 32'd1);
        if_req = 1'b0;

        // halfword store then byte load
        @(posedge clk_in); #1;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd1; ls_addr = 32'h2002; ls_wdata = 32'h0000AABB;
        exp_q.push_back('{is_ls: 1'b1, cmp: 1'b0, data: 32'd0});
        @(posedge clk_in);
        @(negedge clk_in);
        chk("t2_wr_c1", 32'(mem_wr), 32'd1); chk("t2_a_c1", mem_a, 32'h2002); chk("t2_d_c1", 32'(mem_dout), 32'hBB);
        @(negedge clk_in);
        chk("t2_wr_c2", 32'(mem_wr), 32'd1); chk("t2_a_c2", mem_a, 32'h2003); chk("t2_d_c2", 32'(mem_dout), 32'hAA);
        @(negedge clk_in);
        chk("t2_done_c3", 32'(ls_done), 32'd1); chk("t2_wr_c3", 32'(mem_wr), 32'd0);
        ls_req = 1'b0;
        chk("t2_ram", rd(32'h2002, 2), 32'h0000AABB);
        ls_op(1'b0, 2'd0, 32'h2003, 32'd0);
        chk("t2_rdata", ls_rdata, 32'h000000AA);

        // pause during a fetch after the first byte was captured
        exp_q.push_back('{is_ls: 1'b0, cmp: 1'b1, data: 32'h44332211});
        @(posedge clk_in); #1;
        if_req = 1'b1; if_addr = 32'h100;
        @(posedge clk_in);
        @(negedge clk_in); @(negedge clk_in);
        @(posedge clk_in); #1 rdy_in = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            chk("t4_wr_paused", 32'(mem_wr), 32'd0);
        end
        @(posedge clk_in); #1 rdy_in = 1'b1;
        @(negedge clk_in); chk("t4_redrive", mem_a, 32'h101);
        wait_done(1'b0, "t4_if_timeout");
        if_req = 1'b0;

        // pause during a word store: every byte written exactly once
        wc0 = wr_cnt;
        @(posedge clk_in); #1;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd3; ls_addr = 32'h3000; ls_wdata = 32'h11223344;
        exp_q.push_back('{is_ls: 1'b1, cmp: 1'b0, data: 32'd0});
        @(posedge clk_in);
        @(negedge clk_in); chk("t4w_a_c1", mem_a, 32'h3000);
        @(posedge clk_in); #1 rdy_in = 1'b0;
        @(negedge clk_in); chk("t4w_wr_paused", 32'(mem_wr), 32'd0);
        @(posedge clk_in); #1 rdy_in = 1'b1;
        wait_done(1'b1, "t4w_timeout");
        ls_req = 1'b0;
        chk("t4w_wr_cnt", 32'(wr_cnt - wc0), 32'd4);
        chk("t4w_ram", rd(32'h3000, 4), 32'h11223344);

        // flush aborts the fetch, pending load then granted
        @(posedge clk_in); #1;
        if_req = 1'b1; if_addr = 32'h100;
        @(posedge clk_in); #1;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h2002;
        exp_q.push_back('{is_ls: 1'b1, cmp: 1'b1, data: 32'h000000BB});
        @(posedge clk_in);
        @(posedge clk_in); #1 clr_in = 1'b1;
        @(posedge clk_in); #1 clr_in = 1'b0; if_req = 1'b0;
        @(negedge clk_in);
        chk("t5_idle_a", mem_a, 32'd0); chk("t5_no_if_done", 32'(if_done), 32'd0);
        @(negedge clk_in); chk("t5_ls_grant", mem_a, 32'h2002);
        wait_done(1'b1, "t5_ls_timeout");
        ls_req = 1'b0;

        // reset in the middle of a store
        @(posedge clk_in); #1;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd3; ls_addr = 32'h4000; ls_wdata = 32'hCAFEF00D;
        @(posedge clk_in);
        @(negedge clk_in); @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("t6_mem_wr", 32'(mem_wr), 32'd0);
        chk("t6_mem_a", mem_a, 32'd0);
        chk("t6_mem_dout", 32'(mem_dout), 32'd0);
        chk("t6_ls_done", 32'(ls_done), 32'd0);
        ls_req = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        repeat (10) begin
            @(negedge clk_in);
            chk("t6_no_done", 32'(ls_done), 32'd0);
        end

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
